// File: rtl/uart_duplex_engine.sv
// uart_duplex_engine: parametrised full-duplex UART with TX/RX FIFOs, serializer, deserializer and sticky errors.
// Define UART_LOOPBACK_EN to add the loopback port that routes the TX serializer back into the RX path.
module uart_duplex_engine #(
    parameter int DATA_W      = 8,
    parameter int TX_DEPTH    = 8,
    parameter int RX_DEPTH    = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clock,
    input  logic              reset_n,
`ifdef UART_LOOPBACK_EN
    input  logic              loopback,
`endif
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    output logic              tx_full,
    output logic              tx_empty,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              rx_empty,
    output logic              rx_full,
    input  logic [1:0]        parity_type,
    input  logic [15:0]       baud_div,
    input  logic              rxd,
    output logic              txd,
    output logic              tx_busy,
    output logic              tx_done,
    output logic              rx_busy,
    output logic              rx_done,
    output logic [2:0]        err,
    input  logic              err_clr
);
    localparam int TAW = $clog2(TX_DEPTH);
    localparam int RAW = $clog2(RX_DEPTH);
    localparam int BW  = $clog2(DATA_W);

    typedef enum logic [2:0] {T_IDLE, T_LOAD, T_START, T_DATA, T_PARITY, T_STOP} tx_state_t;
    typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_PARITY, R_STOP} rx_state_t;

    tx_state_t         tx_state;
    rx_state_t         rx_state;
    logic [DATA_W-1:0] tx_mem [TX_DEPTH];
    logic [DATA_W-1:0] rx_mem [RX_DEPTH];
    logic [TAW-1:0]    tx_wp, tx_rp;
    logic [RAW-1:0]    rx_wp, rx_rp;
    logic [TAW:0]      tx_cnt;
    logic [RAW:0]      rx_cnt;
    logic              tx_w, tx_r, rx_push, rx_pop;
    logic [15:0]       bd_eff, tx_bd, tx_tick, rx_bd, rx_tick;
    logic [DATA_W-1:0] tx_sh, rx_sh;
    logic [BW-1:0]     tx_bit, rx_bit;
    logic              tx_par, tx_pen, tx_line, tx_end;
    logic [SYNC_STAGES-1:0] rx_sync;
    logic              rx_s, rx_prev, rx_in, rx_pen, rx_odd, rx_par, rx_end, rx_stop;
    logic [2:0]        err_set;

    assign bd_eff   = baud_div < 16'd4 ? 16'd4 : baud_div;
    assign tx_full  = tx_cnt == (TAW+1)'(TX_DEPTH);
    assign tx_empty = tx_cnt == '0;
    assign rx_full  = rx_cnt == (RAW+1)'(RX_DEPTH);
    assign rx_empty = rx_cnt == '0;
    assign tx_w     = wr_en && !tx_full;
    assign tx_r     = tx_state == T_LOAD && !tx_empty;
    assign rx_pop   = rd_en && !rx_empty;
    assign rd_data  = rx_empty ? '0 : rx_mem[rx_rp];
    assign tx_busy  = tx_state != T_IDLE;
    assign rx_busy  = rx_state != R_IDLE;
    assign tx_end   = tx_tick == tx_bd - 16'd1;
    assign rx_end   = rx_tick == rx_bd - 16'd1;
    assign rx_s     = rx_sync[SYNC_STAGES-1];
    assign rx_stop  = rx_state == R_STOP && rx_end;
    assign rx_push  = rx_stop && rx_s && !rx_full;
    assign err_set  = {rx_stop && rx_s && rx_full, rx_stop && !rx_s,
                       rx_stop && rx_s && rx_pen && (rx_par != (^rx_sh ^ rx_odd))};

`ifdef UART_LOOPBACK_EN
    logic lb_q;
    // Loopback only switches while both directions are idle so no frame is ever split.
    always_ff @(posedge clock or negedge reset_n)
        if (!reset_n) lb_q <= 1'b0;
        else if (tx_state == T_IDLE && rx_state == R_IDLE) lb_q <= loopback;
    assign rx_in = lb_q ? tx_line : rxd;
    assign txd   = tx_line | lb_q;
`else
    assign rx_in = rxd;
    assign txd   = tx_line;
`endif

    always_ff @(posedge clock) begin
        if (tx_w) tx_mem[tx_wp] <= wr_data;
        if (rx_push) rx_mem[rx_wp] <= rx_sh;
    end

    always_ff @(posedge clock or negedge reset_n)
        if (!reset_n) begin
            tx_wp  <= '0;
            tx_rp  <= '0;
            tx_cnt <= '0;
            rx_wp  <= '0;
            rx_rp  <= '0;
            rx_cnt <= '0;
        end else begin
            if (tx_w) tx_wp <= tx_wp + TAW'(1);
            if (tx_r) tx_rp <= tx_rp + TAW'(1);
            if (rx_push) rx_wp <= rx_wp + RAW'(1);
            if (rx_pop) rx_rp <= rx_rp + RAW'(1);
            tx_cnt <= tx_cnt + (TAW+1)'(tx_w) - (TAW+1)'(tx_r);
            rx_cnt <= rx_cnt + (RAW+1)'(rx_push) - (RAW+1)'(rx_pop);
        end

    // txd is registered from the transition, so the line changes on the same edge as the state.
    always_ff @(posedge clock or negedge reset_n)
        if (!reset_n) begin
            tx_state <= T_IDLE;
            tx_line  <= 1'b1;
            tx_done  <= 1'b0;
            tx_tick  <= '0;
            tx_bd    <= 16'd4;
            tx_sh    <= '0;
            tx_bit   <= '0;
            tx_par   <= 1'b0;
            tx_pen   <= 1'b0;
        end else begin
            tx_done <= tx_state == T_STOP && tx_tick == tx_bd - 16'd2;
            tx_tick <= tx_end || tx_state inside {T_IDLE, T_LOAD} ? '0 : tx_tick + 16'd1;
            case (tx_state)
                T_IDLE: if (!tx_empty) tx_state <= T_LOAD;
                T_LOAD: begin
                    tx_sh    <= tx_mem[tx_rp];
                    tx_par   <= ^tx_mem[tx_rp] ^ (parity_type == 2'b01);
                    tx_pen   <= parity_type == 2'b01 || parity_type == 2'b10;
                    tx_bd    <= bd_eff;
                    tx_line  <= 1'b0;
                    tx_state <= T_START;
                end
                T_START: if (tx_end) begin
                    tx_line  <= tx_sh[0];
                    tx_bit   <= '0;
                    tx_state <= T_DATA;
                end
                T_DATA: if (tx_end) begin
                    tx_sh  <= tx_sh >> 1;
                    tx_bit <= tx_bit + BW'(1);
                    if (tx_bit == BW'(DATA_W - 1)) begin
                        tx_line  <= tx_pen ? tx_par : 1'b1;
                        tx_state <= tx_pen ? T_PARITY : T_STOP;
                    end else tx_line <= tx_sh[1];
                end
                T_PARITY: if (tx_end) begin
                    tx_line  <= 1'b1;
                    tx_state <= T_STOP;
                end
                T_STOP: if (tx_end) tx_state <= tx_empty ? T_IDLE : T_LOAD;
                default: tx_state <= T_IDLE;
            endcase
        end

    always_ff @(posedge clock or negedge reset_n)
        if (!reset_n) begin
            rx_state <= R_IDLE;
            rx_sync  <= '1;
            rx_prev  <= 1'b1;
            rx_tick  <= '0;
            rx_bd    <= 16'd4;
            rx_sh    <= '0;
            rx_bit   <= '0;
            rx_pen   <= 1'b0;
            rx_odd   <= 1'b0;
            rx_par   <= 1'b0;
            rx_done  <= 1'b0;
            err      <= '0;
        end else begin
            rx_sync <= {rx_sync[SYNC_STAGES-2:0], rx_in};
            rx_prev <= rx_s;
            rx_done <= rx_stop;
            err     <= (err_clr ? 3'b000 : err) | err_set;
            rx_tick <= rx_end || rx_state == R_IDLE ? '0 : rx_tick + 16'd1;
            case (rx_state)
                R_IDLE: if (rx_prev && !rx_s) begin
                    rx_bd    <= bd_eff;
                    rx_pen   <= parity_type == 2'b01 || parity_type == 2'b10;
                    rx_odd   <= parity_type == 2'b01;
                    rx_state <= R_START;
                end
                // Half-bit check rejects glitches and aligns later samples to bit centres.
                R_START: if (rx_tick == (rx_bd >> 1) - 16'd1) begin
                    rx_tick  <= '0;
                    rx_bit   <= '0;
                    rx_state <= rx_s ? R_IDLE : R_DATA;
                end
                R_DATA: if (rx_end) begin
                    rx_sh  <= {rx_s, rx_sh[DATA_W-1:1]};
                    rx_bit <= rx_bit + BW'(1);
                    if (rx_bit == BW'(DATA_W - 1)) rx_state <= rx_pen ? R_PARITY : R_STOP;
                end
                R_PARITY: if (rx_end) begin
                    rx_par   <= rx_s;
                    rx_state <= R_STOP;
                end
                R_STOP: if (rx_end) rx_state <= R_IDLE;
                default: rx_state <= R_IDLE;
            endcase
        end
endmodule

// File: tb/tb_uart_duplex_engine.sv
// tb_uart_duplex_engine: directed checks of the duplex UART at DATA_W=8, depths 8, baud_div=16.
module tb_uart_duplex_engine;
    logic clock = 1'b0, reset_n = 1'b0, wr_en = 1'b0, rd_en = 1'b0, rxd = 1'b1, err_clr = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic [1:0] parity_type = 2'b00;
    logic [15:0] baud_div = 16'd16;
    logic [7:0] rd_data;
    logic tx_full, tx_empty, rx_empty, rx_full, txd, tx_busy, tx_done, rx_busy, rx_done;
    logic [2:0] err;
    int n_chk = 0, n_err = 0, n_rxd = 0;
    int fall, done_at, ndone, base, bad_gap, extra_low, j, o;
    logic busy_mid;
    logic [10:0] frame;
    logic [9:0] f9 [9];

    uart_duplex_engine dut (
        .clock(clock), .reset_n(reset_n),
`ifdef UART_LOOPBACK_EN
        .loopback(1'b0),
`endif
        .wr_en(wr_en), .wr_data(wr_data), .tx_full(tx_full), .tx_empty(tx_empty),
        .rd_en(rd_en), .rd_data(rd_data), .rx_empty(rx_empty), .rx_full(rx_full),
        .parity_type(parity_type), .baud_div(baud_div), .rxd(rxd), .txd(txd),
        .tx_busy(tx_busy), .tx_done(tx_done), .rx_busy(rx_busy), .rx_done(rx_done),
        .err(err), .err_clr(err_clr)
    );

    always #5 clock = ~clock;
    always @(negedge clock) if (rx_done) n_rxd++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drives n bits LSB first, 16 clocks each, starting at a negedge.
    task automatic send_frame(input logic [11:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            rxd = bits[i];
            repeat (16) @(negedge clock);
        end
        rxd = 1'b1;
    endtask

    initial begin
        repeat (3) @(negedge clock);
        check("reset txd", txd, 1);
        check("reset flags", {tx_empty, rx_empty, tx_full, rx_full}, 4'b1100);
        check("reset busy/done", {tx_busy, rx_busy, tx_done, rx_done}, 0);
        check("reset err", err, 0);
        check("reset rd_data", rd_data, 0);
        reset_n = 1'b1;
        repeat (2) @(negedge clock);

        // TX 0xA5, even parity
        parity_type = 2'b10;
        wr_data = 8'hA5;
        wr_en = 1'b1;
        @(posedge clock);
        #1 wr_en = 1'b0;
        fall = -1; done_at = -1; ndone = 0; frame = '0; busy_mid = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clock);
            if (fall < 0 && txd == 1'b0) fall = k;
            if (tx_done) begin
                ndone++;
                if (done_at < 0) done_at = k;
            end
            if (fall >= 0 && (k - fall) % 16 == 8 && (k - fall) / 16 < 11) frame[(k - fall) / 16] = txd;
            if (k == 100) busy_mid = tx_busy;
        end
        check("tx start cycle", fall, 2);
        check("tx a5 frame", frame, 11'h54A);
        check("tx_done cycle", done_at, 177);
        check("tx_done count", ndone, 1);
        check("tx busy mid", busy_mid, 1);
        check("tx idle after", {tx_busy, tx_empty}, 2'b01);

        // RX 0x3C, odd parity, correct then wrong parity bit
        parity_type = 2'b01;
        base = n_rxd;
        send_frame(12'h678, 11);
        repeat (10) @(negedge clock);
        check("rx done count", n_rxd - base, 1);
        check("rx data 3c", rd_data, 8'h3C);
        check("rx not empty", rx_empty, 0);
        check("rx err clean", err, 0);
        rd_en = 1'b1;
        @(negedge clock);
        rd_en = 1'b0;
        check("rx popped", rx_empty, 1);
        send_frame(12'h478, 11);
        repeat (10) @(negedge clock);
        check("rx parity err", err, 3'b001);
        check("rx parity data kept", rd_data, 8'h3C);
        rd_en = 1'b1; err_clr = 1'b1;
        @(negedge clock);
        rd_en = 1'b0; err_clr = 1'b0;
        check("rx parity cleared", {err, rx_empty}, 4'b0001);

        // 9 back-to-back TX writes, 10th while full, parity off
        parity_type = 2'b00;
        wr_data = 8'h00;
        wr_en = 1'b1;
        @(posedge clock);
        bad_gap = 0; extra_low = 0;
        for (int i = 0; i < 9; i++) f9[i] = '0;
        for (int k = 0; k < 1500; k++) begin
            #1;
            if (k < 8) wr_data = 8'(k + 1);
            if (k == 8) begin
                check("tx full after 9", tx_full, 1);
                wr_data = 8'h09;
            end
            wr_en = k < 9;
            @(negedge clock);
            j = (k - 2) / 161;
            o = (k - 2) % 161;
            if (k >= 2 && j < 9) begin
                if (o < 160 && o % 16 == 8) f9[j][o / 16] = txd;
                if (o == 160 && txd !== 1'b1) bad_gap++;
            end
            if (k >= 2 + 161 * 9 && txd !== 1'b1) extra_low++;
            @(posedge clock);
        end
        for (int i = 0; i < 9; i++) check($sformatf("tx burst frame %0d", i), f9[i], {1'b1, 8'(i), 1'b0});
        check("tx burst gaps", bad_gap, 0);
        check("tx no 10th frame", extra_low, 0);
        @(negedge clock);
        check("tx burst idle", {tx_busy, tx_empty}, 2'b01);

        // RX glitch, then a frame with a bad stop bit
        base = n_rxd;
        rxd = 1'b0;
        repeat (4) @(negedge clock);
        rxd = 1'b1;
        repeat (30) @(negedge clock);
        check("glitch no done", n_rxd - base, 0);
        check("glitch err", err, 0);
        check("glitch idle", rx_busy, 0);
        send_frame(12'h0AA, 10);
        repeat (10) @(negedge clock);
        check("frame err done", n_rxd - base, 1);
        check("frame err flag", err, 3'b010);
        check("frame err discarded", rx_empty, 1);
        err_clr = 1'b1;
        @(negedge clock);
        err_clr = 1'b0;
        check("err clear", err, 0);

        // RX overrun: 9 frames without reading
        base = n_rxd;
        for (int i = 0; i < 9; i++) send_frame({3'b001, 8'(16 + i), 1'b0}, 10);
        repeat (10) @(negedge clock);
        check("overrun done count", n_rxd - base, 9);
        check("overrun full", rx_full, 1);
        check("overrun err", err, 3'b100);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("rx fifo order %0d", i), rd_data, 8'(16 + i));
            rd_en = 1'b1;
            @(negedge clock);
            rd_en = 1'b0;
        end
        check("rx drained", {rx_empty, rx_full}, 2'b10);

        // Asynchronous reset in the middle of a data bit
        wr_data = 8'h00;
        wr_en = 1'b1;
        @(negedge clock);
        @(negedge clock);
        wr_en = 1'b0;
        repeat (40) @(negedge clock);
        check("pre-reset line", {txd, tx_busy, tx_empty}, 3'b010);
        #1 reset_n = 1'b0;
        #1;
        check("async reset txd", txd, 1);
        check("async reset busy", tx_busy, 0);
        check("async reset fifos", {tx_empty, rx_empty}, 2'b11);
        @(negedge clock);
        reset_n = 1'b1;
        repeat (2) @(negedge clock);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
